// File: rtl/mem_dbus_if.sv
// rtl/mem_dbus_if.sv - req/ack data bus between the MEM stage and data memory
interface mem_dbus_if;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output stb, we, addr, sel, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  stb, we, addr, sel, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/mem_dbus.sv
// rtl/mem_dbus.sv - MEM pipeline stage with stalling big-endian load/store bus master
module mem_dbus #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        flush,
    output logic        mem_wreg,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_align_err,
    output logic        mem_bus_err,
    output logic        stallreq,
    mem_dbus_if.master  dbus
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
    localparam logic [31:0] ZERO_WORD    = 32'd0;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          stb_q, we_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    sel_q;
    logic [7:0]    op_q;
    logic [1:0]    lane_q;
    logic          load_q, err_q, flush_q;
    logic [TW-1:0] tcnt;

    logic          is_load, is_store, misaligned;
    logic [3:0]    sel_req;
    logic [31:0]   wdata_req;
    logic          start, timeout_hit;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;

    assign dbus.stb   = stb_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.sel   = sel_q;
    assign dbus.wdata = wdata_q;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel_req    = 4'b1111;
        wdata_req  = ex_reg2;
        case (ex_aluop)
            EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin
                is_load    = 1'b1;
                misaligned = ex_mem_addr[0];
            end
            EXE_LW_OP: begin
                is_load    = 1'b1;
                misaligned = |ex_mem_addr[1:0];
            end
            EXE_SB_OP: begin
                is_store  = 1'b1;
                sel_req   = 4'b1000 >> ex_mem_addr[1:0];
                wdata_req = {4{ex_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                is_store   = 1'b1;
                misaligned = ex_mem_addr[0];
                sel_req    = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_req  = {2{ex_reg2[15:0]}};
            end
            EXE_SW_OP: begin
                is_store   = 1'b1;
                misaligned = |ex_mem_addr[1:0];
            end
            default: ;
        endcase
    end

    // Big-endian lanes: byte address 0 lives in rdata[31:24].
    always_comb begin
        case (lane_q)
            2'd0:    byte_v = rdata_q[31:24];
            2'd1:    byte_v = rdata_q[23:16];
            2'd2:    byte_v = rdata_q[15:8];
            default: byte_v = rdata_q[7:0];
        endcase
        half_v = lane_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op_q)
            EXE_LB_OP:  load_data = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_data = {24'd0, byte_v};
            EXE_LH_OP:  load_data = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_data = {16'd0, half_v};
            default:    load_data = rdata_q;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TLAST);

    always_comb begin
        state_nxt     = state;
        start         = 1'b0;
        stallreq      = 1'b0;
        mem_wreg      = 1'b0;
        mem_waddr     = ex_waddr;
        mem_wdata     = ex_wdata;
        mem_align_err = 1'b0;
        mem_bus_err   = 1'b0;
        if (rst) begin
            mem_waddr = NOP_REG_ADDR;
            mem_wdata = ZERO_WORD;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load || is_store) begin
                        if (flush) begin
                            state_nxt = IDLE;
                        end else if (misaligned) begin
                            mem_align_err = 1'b1;
                        end else begin
                            stallreq  = 1'b1;
                            start     = 1'b1;
                            state_nxt = BUSY;
                        end
                    end else begin
                        mem_wreg = ex_wreg & ~flush;
                    end
                end
                BUSY: begin
                    stallreq = 1'b1;
                    if (dbus.err || dbus.ack || timeout_hit)
                        state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                    // A flushed instruction is silently dropped, even if its bus cycle failed.
                    if (flush_q || flush) begin
                        mem_wreg = 1'b0;
                    end else if (err_q) begin
                        mem_bus_err = 1'b1;
                    end else begin
                        mem_wreg = ex_wreg;
                        if (load_q)
                            mem_wdata = load_data;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            op_q    <= 8'd0;
            lane_q  <= 2'd0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            tcnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        stb_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {ex_mem_addr[31:2], 2'b00};
                        sel_q   <= sel_req;
                        wdata_q <= wdata_req;
                        op_q    <= ex_aluop;
                        lane_q  <= ex_mem_addr[1:0];
                        load_q  <= is_load;
                        err_q   <= 1'b0;
                        flush_q <= 1'b0;
                        tcnt    <= '0;
                    end
                end
                BUSY: begin
                    // The bus cycle always runs to completion; flush only suppresses writeback.
                    if (flush)
                        flush_q <= 1'b1;
                    if (dbus.err || timeout_hit) begin
                        stb_q <= 1'b0;
                        err_q <= 1'b1;
                    end else if (dbus.ack) begin
                        stb_q   <= 1'b0;
                        rdata_q <= dbus.rdata;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dbus.sv
// tb/tb_mem_dbus.sv - scoreboard bench for mem_dbus with a scripted bus slave
module tb_mem_dbus;
    localparam int TMO = 8;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_align_err;
    logic        mem_bus_err;
    logic        stallreq;

    mem_dbus_if bus ();

    mem_dbus #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wreg       (ex_wreg),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .ex_aluop      (ex_aluop),
        .ex_mem_addr   (ex_mem_addr),
        .ex_reg2       (ex_reg2),
        .flush         (flush),
        .mem_wreg      (mem_wreg),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .mem_align_err (mem_align_err),
        .mem_bus_err   (mem_bus_err),
        .stallreq      (stallreq),
        .dbus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        bus_err;
        logic        align_err;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          k;
        logic [31:0] v;
        k = int'(a[1:0]);
        case (op)
            OP_LB, OP_LBU: begin
                v = (rd >> (8 * (3 - k))) & 32'h0000_00FF;
                if (op == OP_LB && v[7]) v = v | 32'hFFFF_FF00;
            end
            OP_LH, OP_LHU: begin
                v = (rd >> (8 * (2 - k))) & 32'h0000_FFFF;
                if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] a);
        if (op == OP_SB) return 4'(4'b0001 << (3 - int'(a[1:0])));
        if (op == OP_SH) return a[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_bus_wdata(input logic [7:0] op, input logic [31:0] r2);
        if (op == OP_SB) return {24'd0, r2[7:0]} * 32'h0101_0101;
        if (op == OP_SH) return {16'd0, r2[15:0]} * 32'h0001_0001;
        return r2;
    endfunction

    // ack_n: strobe cycle that gets ack (0 = never); flush_n: strobe cycle with flush (0 = none)
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                          input logic [31:0] wd, input logic [4:0] wa, input logic wr,
                          input int ack_n, input logic [31:0] rd, input logic use_err,
                          input int flush_n, input string name);
        exp_t e;
        exp_t got_e;
        int   sz;
        int   stall_cnt;
        int   stb_cnt;
        bit   done;
        bit   mis;
        sz  = op_size(op);
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        if (sz == 0) begin
            e = '{wr, wa, wd, 1'b0, 1'b0, 0};
        end else if (mis) begin
            e = '{1'b0, wa, wd, 1'b0, 1'b1, 0};
        end else begin
            e.stall     = ((ack_n > 0) ? ack_n : TMO) + 1;
            e.bus_err   = (ack_n == 0) || use_err;
            e.align_err = 1'b0;
            e.waddr     = wa;
            e.wreg      = wr && !e.bus_err && (flush_n == 0);
            e.wdata     = op_store(op) ? wd : exp_load(op, a, rd);
        end
        ex_aluop = op; ex_mem_addr = a; ex_reg2 = r2;
        ex_wdata = wd; ex_waddr = wa; ex_wreg = wr;
        sb.push_back(e);
        stall_cnt = 0;
        stb_cnt   = 0;
        done      = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (bus.stb) begin
                stb_cnt++;
                if (stb_cnt == 1) begin
                    check({name, ".addr"}, bus.addr, {a[31:2], 2'b00});
                    check({name, ".sel"}, {28'd0, bus.sel}, {28'd0, exp_sel(op, a)});
                    check({name, ".we"}, {31'd0, bus.we}, {31'd0, op_store(op)});
                    if (op_store(op))
                        check({name, ".bus_wdata"}, bus.wdata, exp_bus_wdata(op, r2));
                end
                if (stb_cnt == ack_n) begin
                    bus.ack   = 1'b1;
                    bus.err   = use_err;
                    bus.rdata = rd;
                end
                flush = (flush_n > 0) && (stb_cnt == flush_n);
            end
            @(negedge clk);
            if (stallreq) begin
                stall_cnt++;
            end else begin
                done  = 1;
                got_e = sb.pop_front();
                check({name, ".wreg"}, {31'd0, mem_wreg}, {31'd0, got_e.wreg});
                check({name, ".waddr"}, {27'd0, mem_waddr}, {27'd0, got_e.waddr});
                if (got_e.wreg)
                    check({name, ".wdata"}, mem_wdata, got_e.wdata);
                check({name, ".bus_err"}, {31'd0, mem_bus_err}, {31'd0, got_e.bus_err});
                check({name, ".align_err"}, {31'd0, mem_align_err}, {31'd0, got_e.align_err});
                check({name, ".stall"}, stall_cnt, got_e.stall);
                check({name, ".stb_cycles"}, stb_cnt, (got_e.stall > 0) ? got_e.stall - 1 : 0);
            end
            @(posedge clk);
            #1;
            bus.ack = 1'b0;
            bus.err = 1'b0;
            flush   = 1'b0;
        end
        if (!done) begin
            check({name, ".no_result"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        ex_aluop = OP_ADD;
        ex_wreg  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        ex_wreg = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234_5678;
        ex_aluop = OP_LW; ex_mem_addr = 32'h100; ex_reg2 = 32'd0;
        bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.wreg", {31'd0, mem_wreg}, 32'd0);
        check("rst.waddr", {27'd0, mem_waddr}, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        check("rst.stall", {31'd0, stallreq}, 32'd0);
        check("rst.stb", {31'd0, bus.stb}, 32'd0);
        check("rst.sel", {28'd0, bus.sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(OP_ADD, 32'h0,   32'h0,        32'hCAFE_0001, 5'd3, 1'b1, 0, 32'h0,         1'b0, 0, "alu");
        run_op(OP_LW,  32'h100, 32'h0,        32'h100,       5'd4, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, "lw");
        run_op(OP_LB,  32'h103, 32'h0,        32'h103,       5'd6, 1'b1, 1, 32'h1234_56F0, 1'b0, 0, "lb");
        run_op(OP_LBU, 32'h103, 32'h0,        32'h103,       5'd7, 1'b1, 1, 32'h1234_56F0, 1'b0, 0, "lbu");
        run_op(OP_LB,  32'h101, 32'h0,        32'h101,       5'd7, 1'b1, 2, 32'h1281_56F0, 1'b0, 0, "lb1");
        run_op(OP_LH,  32'h102, 32'h0,        32'h102,       5'd8, 1'b1, 1, 32'h1234_8001, 1'b0, 0, "lh");
        run_op(OP_LHU, 32'h100, 32'h0,        32'h100,       5'd9, 1'b1, 2, 32'h8001_1234, 1'b0, 0, "lhu");
        run_op(OP_SH,  32'h102, 32'h0000_ABCD, 32'h102,      5'd0, 1'b0, 1, 32'h0,         1'b0, 0, "sh");
        run_op(OP_SB,  32'h101, 32'h0000_0055, 32'h101,      5'd0, 1'b0, 1, 32'h0,         1'b0, 0, "sb");
        run_op(OP_SW,  32'h104, 32'h89AB_CDEF, 32'h104,      5'd2, 1'b1, 2, 32'h0,         1'b0, 0, "sw");
        run_op(OP_LW,  32'h101, 32'h0,        32'h101,       5'd4, 1'b1, 1, 32'h0,         1'b0, 0, "lw_mis");
        run_op(OP_SH,  32'h103, 32'h0,        32'h103,       5'd4, 1'b0, 1, 32'h0,         1'b0, 0, "sh_mis");
        run_op(OP_LW,  32'h200, 32'h0,        32'h200,       5'd4, 1'b1, 0, 32'h0,         1'b0, 0, "timeout");
        run_op(OP_LW,  32'h204, 32'h0,        32'h204,       5'd4, 1'b1, 2, 32'h5555_AAAA, 1'b1, 0, "err_ack");
        run_op(OP_LW,  32'h208, 32'h0,        32'h208,       5'd4, 1'b1, 4, 32'h7777_0000, 1'b0, 2, "flush");
        run_op(OP_LW,  32'h20C, 32'h0,        32'h20C,       5'd11, 1'b1, 1, 32'h0BAD_F00D, 1'b0, 0, "after_flush");

        // Reset in the middle of a bus cycle.
        ex_aluop = OP_LW; ex_mem_addr = 32'h300; ex_wreg = 1'b1; ex_waddr = 5'd12; ex_wdata = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst.stb_before", {31'd0, bus.stb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.stall", {31'd0, stallreq}, 32'd0);
        check("midrst.wreg", {31'd0, mem_wreg}, 32'd0);
        check("midrst.wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        check("midrst.stb", {31'd0, bus.stb}, 32'd0);
        check("midrst.addr", bus.addr, 32'd0);
        rst = 1'b0;
        ex_aluop = OP_ADD; ex_wreg = 1'b0;
        @(negedge clk);
        check("midrst.idle_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        run_op(OP_LW, 32'h310, 32'h0, 32'h310, 5'd13, 1'b1, 2, 32'h0123_4567, 1'b0, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
